// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fp_add_arbiter (with FPAdder)
// Brief   : Two-requester round-robin arbiter sharing one combinational IEEE-754
//           adder behind a two-stage registered pipeline with tagged response.
//           Optional macro FP_ADD_ARBITER_SUB_EN enables A-B via reqN_sub.
// Revision: 1.0 - initial release
// ============================================================================

module FPAdder #(
   parameter int BUS_WIDTH = 64
) (
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   output logic [BUS_WIDTH-1:0] y
);
   localparam int EW = (BUS_WIDTH == 32) ? 8 : 11;
   localparam int FW = BUS_WIDTH - 1 - EW;
   localparam int M  = FW + 4;   // hidden + fraction + guard/round/sticky
   localparam int XW = EW + 2;
   localparam logic [EW-1:0]        EMAX = '1;
   localparam logic [BUS_WIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};

   logic          sa, sb, s_big, s_res, eff_sub, swap;
   logic [EW-1:0] ea, eb;
   logic [FW-1:0] fa, fb;
   logic          a_nan, b_nan, a_inf, b_inf, round_up;
   logic [XW-1:0] ea_x, eb_x, e_big, e_sml, e_diff, e_res;
   logic [M-1:0]  ma, mb, m_big, m_sml, m_shf, mask, norm;
   logic [M:0]    sum;
   logic [FW+1:0] rnd;
   int            lz, sh;

   always_comb begin
      {sa, ea, fa} = a;
      {sb, eb, fb} = b;
      a_nan  = (ea == EMAX) && (fa != '0);
      b_nan  = (eb == EMAX) && (fb != '0);
      a_inf  = (ea == EMAX) && (fa == '0);
      b_inf  = (eb == EMAX) && (fb == '0);
      ea_x   = (ea == '0) ? XW'(1) : XW'(ea);
      eb_x   = (eb == '0) ? XW'(1) : XW'(eb);
      ma     = {ea != '0, fa, 3'b000};
      mb     = {eb != '0, fb, 3'b000};
      swap   = {eb, fb} > {ea, fa};
      s_big  = swap ? sb : sa;
      e_big  = swap ? eb_x : ea_x;
      e_sml  = swap ? ea_x : eb_x;
      m_big  = swap ? mb : ma;
      m_sml  = swap ? ma : mb;
      e_diff = e_big - e_sml;
      mask   = '0;
      m_shf  = '0;
      lz     = M;
      sh     = 0;

      // Alignment shift keeps everything shifted out as a sticky bit
      if (e_diff >= XW'(M)) begin
         m_shf[0] = |m_sml;
      end else begin
         mask     = ~({M{1'b1}} << e_diff);
         m_shf    = m_sml >> e_diff;
         m_shf[0] = m_shf[0] | (|(m_sml & mask));
      end

      eff_sub = sa ^ sb;
      sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_shf})
                        : ({1'b0, m_big} + {1'b0, m_shf});

      if (sum[M]) begin
         norm    = sum[M:1];
         norm[0] = sum[1] | sum[0];
         e_res   = e_big + XW'(1);
      end else begin
         for (int i = 0; i < M; i++) begin
            if (sum[i]) lz = M - 1 - i;
         end
         // Never normalise below the minimum exponent; leaves a subnormal
         sh    = (lz < int'(e_big) - 1) ? lz : int'(e_big) - 1;
         norm  = sum[M-1:0] << sh;
         e_res = e_big - XW'(sh);
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd      = {1'b0, norm[M-1:3]} + (FW+2)'(round_up);
      if (rnd[FW+1]) begin
         rnd   = rnd >> 1;
         e_res = e_res + XW'(1);
      end

      s_res = (sum == '0) ? (sa & sb) : s_big;
      if (e_res >= XW'(EMAX))
         y = {s_res, EMAX, {FW{1'b0}}};
      else
         y = {s_res, (rnd[FW] ? e_res[EW-1:0] : {EW{1'b0}}), rnd[FW-1:0]};

      if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb)))
         y = QNAN;
      else if (a_inf)
         y = a;
      else if (b_inf)
         y = b;
   end
endmodule

module fp_add_arbiter #(
   parameter int BUS_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [BUS_WIDTH-1:0] req0_a,
   input  logic [BUS_WIDTH-1:0] req0_b,
   input  logic                 req0_sub,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [BUS_WIDTH-1:0] req1_a,
   input  logic [BUS_WIDTH-1:0] req1_b,
   input  logic                 req1_sub,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [BUS_WIDTH-1:0] resp_data,
   output logic                 resp_id,
   output logic                 busy
);
   logic                 s1_valid_q, s1_valid_d;
   logic [BUS_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic                 s1_id_q, s1_id_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [BUS_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                 resp_id_q, resp_id_d;
   logic                 last_q, last_d;

   logic                 s1_en, s2_en, grant, hs;
   logic [BUS_WIDTH-1:0] a_sel, b_sel, sum;

`ifdef FP_ADD_ARBITER_SUB_EN
   assign b_sel = grant ? {req1_b[BUS_WIDTH-1] ^ req1_sub, req1_b[BUS_WIDTH-2:0]}
                        : {req0_b[BUS_WIDTH-1] ^ req0_sub, req0_b[BUS_WIDTH-2:0]};
`else
   logic unused_sub;
   assign unused_sub = req0_sub ^ req1_sub;
   assign b_sel      = grant ? req1_b : req0_b;
`endif
   assign a_sel = grant ? req1_a : req0_a;

   FPAdder #(.BUS_WIDTH(BUS_WIDTH)) u_adder (
      .a (s1_a_q),
      .b (s1_b_q),
      .y (sum)
   );

   always_comb begin
      s2_en = ~resp_valid_q | resp_ready;
      s1_en = ~s1_valid_q | s2_en;
      // Contention goes to the requester not granted most recently
      grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      req0_ready = s1_en & req0_valid & ~grant;
      req1_ready = s1_en & req1_valid &  grant;
      hs = req0_ready | req1_ready;

      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_id_d      = s1_id_q;
      last_d       = last_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;

      if (s1_en) begin
         s1_valid_d = hs;
         if (hs) begin
            s1_a_d  = a_sel;
            s1_b_d  = b_sel;
            s1_id_d = grant;
            last_d  = grant;
         end
      end
      if (s2_en) begin
         resp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            resp_data_d = sum;
            resp_id_d   = s1_id_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_id_q      <= 1'b0;
         last_q       <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_id_q    <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_id_q      <= s1_id_d;
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;
   assign busy       = s1_valid_q | resp_valid_q;
endmodule
`default_nettype wire
